// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: power-up init and page refresh sequencer for a 16x2
// HD44780-compatible character LCD. Walks the 32-byte message ROM (row 0 =
// addresses 0-15, row 1 = 16-31) and rewrites the panel whenever the
// synchronized page select changes.
module lcd_refresh_ctrl #(
    parameter int T_PWR = 1000000,
    parameter int T_EN  = 25,
    parameter int T_CMD = 2500,
    parameter int T_CLR = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    output logic [4:0] raddr,
    input  logic [7:0] dout,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       busy
);

    localparam int TMAX = (T_PWR > T_CLR) ? ((T_PWR > T_CMD) ? T_PWR : T_CMD)
                                          : ((T_CLR > T_CMD) ? T_CLR : T_CMD);
    localparam int TM2  = (TMAX > T_EN) ? TMAX : T_EN;
    localparam int CW   = $clog2(TM2 + 1);

    localparam logic [CW-1:0] PWR_L = CW'(T_PWR - 1);
    localparam logic [CW-1:0] EN_L  = CW'(T_EN - 1);
    localparam logic [CW-1:0] CMD_L = CW'(T_CMD - 1);
    localparam logic [CW-1:0] CLR_L = CW'(T_CLR - 1);

    // st names the write currently in flight; ph is its position in the
    // SETUP / enable-high / settle-wait sub-sequence.
    typedef enum logic [2:0] {
        PWR_WAIT, INIT, ROW0_ADDR, ROW0_CHAR, ROW1_ADDR, ROW1_CHAR, IDLE
    } st_t;
    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} ph_t;

    st_t           st, nst;
    ph_t           ph;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wait_last;
    logic [3:0]    idx, nidx;
    logic [7:0]    ndata;
    logic          nrs;
    logic          adv;
    logic [1:0]    sw_m, sw_s, sw_cur;

    assign lcd_rw = 1'b0;
    assign lcd_on = 1'b1;

    // Clear-display needs the long settle time; everything else the short one.
    assign wait_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_L : CMD_L;

    // Two-flop synchronizer for the asynchronous page switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m <= 2'b00;
            sw_s <= 2'b00;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // Next write in the sequence and the byte it puts on the bus.
    always_comb begin
        nst  = st;
        nidx = idx + 4'd1;
        case (st)
            PWR_WAIT:  begin nst = INIT;      nidx = 4'd0; end
            INIT:      if (idx == 4'd3) begin nst = ROW0_ADDR; nidx = 4'd0; end
            ROW0_ADDR: begin nst = ROW0_CHAR; nidx = 4'd0; end
            ROW0_CHAR: if (idx == 4'd15) begin nst = ROW1_ADDR; nidx = 4'd0; end
            ROW1_ADDR: begin nst = ROW1_CHAR; nidx = 4'd0; end
            ROW1_CHAR: if (idx == 4'd15) nst = IDLE;
            IDLE:      begin nst = ROW0_ADDR; nidx = 4'd0; end
            default:   nst = PWR_WAIT;
        endcase
        nrs   = 1'b0;
        ndata = 8'h00;
        case (nst)
            INIT: begin
                case (nidx[1:0])
                    2'd0:    ndata = 8'h38;
                    2'd1:    ndata = 8'h0C;
                    2'd2:    ndata = 8'h01;
                    default: ndata = 8'h06;
                endcase
            end
            ROW0_ADDR: ndata = 8'h80;
            ROW1_ADDR: ndata = 8'hC0;
            ROW0_CHAR, ROW1_CHAR: begin
                nrs   = 1'b1;
                ndata = dout;
            end
            default: ;
        endcase
    end

    // Points where the sequencer moves on to the next write (or to IDLE).
    always_comb begin
        adv = 1'b0;
        case (st)
            PWR_WAIT: adv = (cnt == PWR_L);
            IDLE:     adv = (sw_s != sw_cur);
            default:  adv = (ph == PH_WAIT) && (cnt == wait_last);
        endcase
    end

    // Main sequencer: top-level progress plus the per-write strobe timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= PWR_WAIT;
            ph       <= PH_SETUP;
            cnt      <= '0;
            idx      <= 4'd0;
            raddr    <= 5'd0;
            lcd_data <= 8'h00;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            busy     <= 1'b1;
            sw_cur   <= 2'b00;
        end else if (adv) begin
            cnt <= '0;
            if (nst == IDLE) begin
                st   <= IDLE;
                busy <= 1'b0;
            end else begin
                st       <= nst;
                idx      <= nidx;
                ph       <= PH_SETUP;
                lcd_data <= ndata;
                lcd_rs   <= nrs;
                busy     <= 1'b1;
                // A page's content is committed when its row 0 starts.
                if (nst == ROW0_ADDR)
                    sw_cur <= sw_s;
            end
        end else begin
            case (st)
                PWR_WAIT: cnt <= cnt + 1'b1;
                IDLE:     ;
                default: begin
                    case (ph)
                        PH_SETUP: begin
                            ph     <= PH_EN;
                            lcd_en <= 1'b1;
                            cnt    <= '0;
                        end
                        PH_EN: begin
                            if (cnt == EN_L) begin
                                ph     <= PH_WAIT;
                                lcd_en <= 1'b0;
                                cnt    <= '0;
                                // Pre-address the next character during the wait.
                                if (lcd_rs)
                                    raddr <= raddr + 5'd1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: cnt <= cnt + 1'b1;
                    endcase
                end
            endcase
        end
    end

endmodule
